// File: rtl/fp_adder_arbiter_pkg.sv
// Shared types and helpers for the LDPC floating-point adder sharing logic.
package ldpc_fp_pkg;

    localparam int unsigned FP_W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        HOLD = 2'd1,
        RESP = 2'd2
    } state_t;

    // Unused mask bits must be zero, which makes a mod-16 scan equal to a mod-NUM_REQ scan.
    function automatic logic [3:0] rr_pick(input logic [15:0] mask, input logic [3:0] ptr);
        logic [3:0] idx;
        logic       found;
        found   = 1'b0;
        rr_pick = '0;
        for (int unsigned k = 0; k < 16; k++) begin
            idx = ptr + 4'(k);
            if (!found && mask[idx]) begin
                found   = 1'b1;
                rr_pick = idx;
            end
        end
    endfunction

endpackage

// File: rtl/fp_adder_arbiter_if.sv
// Requester, adder and response signals of the shared FP adder arbiter.
interface fp_adder_arbiter_if import ldpc_fp_pkg::*; #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
);
    logic [NUM_REQ-1:0]      req_valid;
    logic [NUM_REQ-1:0]      req_ready;
    logic [FP_W*NUM_REQ-1:0] req_a;
    logic [FP_W*NUM_REQ-1:0] req_b;
    logic [FP_W-1:0]         add_in1;
    logic [FP_W-1:0]         add_in2;
    logic [FP_W-1:0]         add_out;
    logic                    resp_valid;
    logic                    resp_ready;
    logic [FP_W-1:0]         resp_data;
    logic [ID_W-1:0]         resp_id;
    logic                    busy;

    modport slave (
        input  req_valid, req_a, req_b, add_out, resp_ready,
        output req_ready, add_in1, add_in2, resp_valid, resp_data, resp_id, busy
    );

    modport master (
        output req_valid, req_a, req_b, add_out, resp_ready,
        input  req_ready, add_in1, add_in2, resp_valid, resp_data, resp_id, busy
    );
endinterface

// File: rtl/fp_adder_arbiter_rr_arbiter.sv
// Combinational round-robin pick: first valid requester at or above the pointer, wrapping.
module rr_arbiter import ldpc_fp_pkg::*; #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] i_req_valid,
    input  logic [ID_W-1:0]    i_ptr,
    output logic [NUM_REQ-1:0] o_grant,
    output logic [ID_W-1:0]    o_idx,
    output logic               o_any
);
    logic [15:0] w_mask;
    logic [3:0]  w_pick;

    always_comb begin
        w_mask               = '0;
        w_mask[NUM_REQ-1:0]  = i_req_valid;
    end

    assign w_pick = rr_pick(w_mask, 4'(i_ptr));
    assign o_idx  = ID_W'(w_pick);
    assign o_any  = |i_req_valid;

    always_comb begin
        o_grant = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            o_grant[i] = o_any && (w_pick == 4'(i));
        end
    end
endmodule

// File: rtl/fp_adder_arbiter.sv
// Round-robin sharing of one external multicycle FP adder among NUM_REQ requesters,
// returning the registered sum tagged with the requester index.
module fp_adder_arbiter import ldpc_fp_pkg::*; #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned ID_W       = 2,
    parameter int unsigned ADD_CYCLES = 2
) (
    input logic               clk,
    input logic               rst_n,
    fp_adder_arbiter_if.slave bus
);
    state_t             r_state;
    state_t             w_state_nxt;
    logic [ID_W-1:0]    r_ptr;
    logic [ID_W-1:0]    r_id;
    logic [ID_W-1:0]    w_idx;
    logic [NUM_REQ-1:0] w_grant;
    logic               w_any;
    logic               w_accept;
    logic [3:0]         r_cnt;
    logic [FP_W-1:0]    r_in1;
    logic [FP_W-1:0]    r_in2;
    logic [FP_W-1:0]    r_data;
    logic [FP_W-1:0]    w_a;
    logic [FP_W-1:0]    w_b;

    rr_arbiter #(
        .NUM_REQ (NUM_REQ),
        .ID_W    (ID_W)
    ) u_arb (
        .i_req_valid (bus.req_valid),
        .i_ptr       (r_ptr),
        .o_grant     (w_grant),
        .o_idx       (w_idx),
        .o_any       (w_any)
    );

    assign w_accept = (r_state == IDLE) && w_any;

    always_comb begin
        w_a = '0;
        w_b = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (w_grant[i]) begin
                w_a = w_a | bus.req_a[i*FP_W +: FP_W];
                w_b = w_b | bus.req_b[i*FP_W +: FP_W];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            IDLE:    if (w_any) w_state_nxt = HOLD;
            HOLD:    if (r_cnt == '0) w_state_nxt = RESP;
            RESP:    if (bus.resp_ready) w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    // Operands stay frozen from accept until the sum is sampled, so the adder sees a multicycle path.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr  <= '0;
            r_id   <= '0;
            r_cnt  <= '0;
            r_in1  <= '0;
            r_in2  <= '0;
            r_data <= '0;
        end else if (w_accept) begin
            r_in1 <= w_a;
            r_in2 <= w_b;
            r_id  <= w_idx;
            r_ptr <= (32'(w_idx) == NUM_REQ - 1) ? '0 : w_idx + 1'b1;
            r_cnt <= 4'(ADD_CYCLES - 1);
        end else if (r_state == HOLD) begin
            if (r_cnt != '0) begin
                r_cnt <= r_cnt - 1'b1;
            end else begin
                r_data <= bus.add_out;
            end
        end
    end

    always_comb begin
        bus.req_ready  = '0;
        if (r_state == IDLE) bus.req_ready = w_grant;
        bus.busy       = (r_state != IDLE);
        bus.resp_valid = (r_state == RESP);
        bus.add_in1    = r_in1;
        bus.add_in2    = r_in2;
        bus.resp_data  = r_data;
        bus.resp_id    = r_id;
    end
endmodule

// File: tb/tb_fp_adder_arbiter.sv
// Directed bench for fp_adder_arbiter: two instances (ADD_CYCLES=2 and 1) each driving a small FP adder model.
module tb_fp_adder_arbiter;

    localparam logic [31:0] ONE   = 32'h3F800000;
    localparam logic [31:0] TWO   = 32'h40000000;
    localparam logic [31:0] THREE = 32'h40400000;
    localparam logic [31:0] FOUR  = 32'h40800000;
    localparam logic [31:0] TEN   = 32'h41200000;
    localparam logic [31:0] HALF  = 32'h3F000000;
    localparam logic [31:0] QUART = 32'h3E800000;
    localparam logic [31:0] P75   = 32'h3F400000;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    fp_adder_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus  ();
    fp_adder_arbiter_if #(.NUM_REQ(4), .ID_W(2)) bus1 ();

    fp_adder_arbiter #(.NUM_REQ(4), .ID_W(2), .ADD_CYCLES(2)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    fp_adder_arbiter #(.NUM_REQ(4), .ID_W(2), .ADD_CYCLES(1)) u_dut1 (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus1)
    );

    // Positive normal numbers only; enough for the operand values used here.
    function automatic logic [31:0] fp_add(input logic [31:0] x, input logic [31:0] y);
        logic [31:0] a;
        logic [31:0] b;
        logic [7:0]  e;
        logic [24:0] ma;
        logic [24:0] mb;
        logic [24:0] s;
        if (x[30:23] >= y[30:23]) begin a = x; b = y; end
        else begin a = y; b = x; end
        if (b[30:0] == '0) return a;
        e  = a[30:23];
        ma = {2'b01, a[22:0]};
        mb = {2'b01, b[22:0]} >> (a[30:23] - b[30:23]);
        s  = ma + mb;
        if (s[24]) begin s = s >> 1; e = e + 8'd1; end
        return {1'b0, e, s[22:0]};
    endfunction

    always_comb bus.add_out  = fp_add(bus.add_in1, bus.add_in2);
    always_comb bus1.add_out = fp_add(bus1.add_in1, bus1.add_in2);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input bit which, input int i, input logic [31:0] a, input logic [31:0] b);
        if (which) begin
            bus1.req_a[i*32 +: 32] = a;
            bus1.req_b[i*32 +: 32] = b;
        end else begin
            bus.req_a[i*32 +: 32] = a;
            bus.req_b[i*32 +: 32] = b;
        end
    endtask

    task automatic clear_inputs();
        bus.req_valid   = '0;
        bus.req_a       = '0;
        bus.req_b       = '0;
        bus.resp_ready  = 1'b0;
        bus1.req_valid  = '0;
        bus1.req_a      = '0;
        bus1.req_b      = '0;
        bus1.resp_ready = 1'b0;
    endtask

    task automatic apply_reset();
        clear_inputs();
        #1 rst_n = 1'b0;
        #2 rst_n = 1'b1;
        tick();
    endtask

    task automatic wait_resp(input bit which, output int lat);
        lat = 1;
        while (((which ? bus1.resp_valid : bus.resp_valid) !== 1'b1) && lat < 20) begin
            tick();
            lat++;
        end
    endtask

    task automatic wait_grant(input bit which, output int w);
        w = 0;
        while (((which ? bus1.req_ready : bus.req_ready) == '0) && w < 20) begin
            tick();
            #1;
            w++;
        end
    endtask

    task automatic test_reset();
        clear_inputs();
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if ({bus.req_ready, bus.add_in1, bus.add_in2, bus.resp_valid, bus.resp_data, bus.resp_id, bus.busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_dut0: outputs=%h expected all 0",
                     {bus.req_ready, bus.add_in1, bus.add_in2, bus.resp_valid, bus.resp_data, bus.resp_id, bus.busy});
        end
        n_tests++;
        if ({bus1.req_ready, bus1.add_in1, bus1.add_in2, bus1.resp_valid, bus1.resp_data, bus1.resp_id, bus1.busy} !== '0) begin
            n_fail++;
            $display("FAIL reset_dut1: outputs=%h expected all 0",
                     {bus1.req_ready, bus1.add_in1, bus1.add_in2, bus1.resp_valid, bus1.resp_data, bus1.resp_id, bus1.busy});
        end
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single();
        int lat;
        set_op(0, 0, ONE, TWO);
        bus.req_valid = 4'b0001;
        #1;
        n_tests++;
        if (bus.req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL single_ready: got %b expected 0001", bus.req_ready);
        end
        tick();
        bus.req_valid = '0;
        wait_resp(0, lat);
        n_tests++;
        if (lat != 3) begin
            n_fail++;
            $display("FAIL single_latency: got %0d expected 3", lat);
        end
        n_tests++;
        if (bus.resp_data !== THREE || bus.resp_id !== 2'd0 || bus.busy !== 1'b1) begin
            n_fail++;
            $display("FAIL single_resp: data=%h id=%0d busy=%b expected 40400000 0 1", bus.resp_data, bus.resp_id, bus.busy);
        end
        bus.resp_ready = 1'b1;
        tick();
        n_tests++;
        if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL single_release: resp_valid=%b busy=%b expected 0 0", bus.resp_valid, bus.busy);
        end
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_round_robin();
        int w;
        int lat;
        apply_reset();
        for (int i = 0; i < 4; i++) set_op(0, i, HALF, QUART);
        bus.resp_ready = 1'b1;
        bus.req_valid  = 4'hF;
        #1;
        for (int g = 0; g < 5; g++) begin
            wait_grant(0, w);
            n_tests++;
            if (bus.req_ready !== 4'(1 << (g % 4))) begin
                n_fail++;
                $display("FAIL rr_grant%0d: got %b expected %b", g, bus.req_ready, 4'(1 << (g % 4)));
            end
            if (g > 0) begin
                n_tests++;
                if (w != 0) begin
                    n_fail++;
                    $display("FAIL rr_throughput%0d: extra idle cycles %0d expected 0", g, w);
                end
            end
            tick();
            wait_resp(0, lat);
            if (g == 4) bus.req_valid = '0;
            n_tests++;
            if (lat != 3 || bus.resp_data !== P75 || bus.resp_id !== 2'(g % 4)) begin
                n_fail++;
                $display("FAIL rr_resp%0d: lat=%0d data=%h id=%0d expected 3 3f400000 %0d",
                         g, lat, bus.resp_data, bus.resp_id, g % 4);
            end
            tick();
            #1;
        end
        n_tests++;
        if (bus.busy !== 1'b0 || bus.resp_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL rr_idle: busy=%b resp_valid=%b expected 0 0", bus.busy, bus.resp_valid);
        end
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_backpressure();
        int lat;
        set_op(0, 1, THREE, ONE);
        bus.req_valid = 4'b0110;
        #1;
        n_tests++;
        if (bus.req_ready !== 4'b0010) begin
            n_fail++;
            $display("FAIL bp_grant: got %b expected 0010", bus.req_ready);
        end
        tick();
        bus.req_valid = 4'b0100;
        wait_resp(0, lat);
        n_tests++;
        if (lat != 3 || bus.resp_data !== FOUR || bus.resp_id !== 2'd1) begin
            n_fail++;
            $display("FAIL bp_resp: lat=%0d data=%h id=%0d expected 3 40800000 1", lat, bus.resp_data, bus.resp_id);
        end
        for (int k = 0; k < 5; k++) begin
            tick();
            n_tests++;
            if (bus.resp_valid !== 1'b1 || bus.resp_data !== FOUR || bus.resp_id !== 2'd1 || bus.req_ready !== 4'b0000) begin
                n_fail++;
                $display("FAIL bp_hold%0d: valid=%b data=%h id=%0d ready=%b expected 1 40800000 1 0000",
                         k, bus.resp_valid, bus.resp_data, bus.resp_id, bus.req_ready);
            end
        end
        bus.resp_ready = 1'b1;
        tick();
        #1;
        n_tests++;
        if (bus.resp_valid !== 1'b0 || bus.req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL bp_release: valid=%b ready=%b expected 0 0100", bus.resp_valid, bus.req_ready);
        end
        tick();
        bus.req_valid = '0;
        wait_resp(0, lat);
        n_tests++;
        if (lat != 3 || bus.resp_data !== P75 || bus.resp_id !== 2'd2) begin
            n_fail++;
            $display("FAIL bp_next: lat=%0d data=%h id=%0d expected 3 3f400000 2", lat, bus.resp_data, bus.resp_id);
        end
        tick();
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_operand_stability();
        set_op(0, 0, ONE, TWO);
        bus.req_valid = 4'b0001;
        #1;
        n_tests++;
        if (bus.req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL stab_grant: got %b expected 0001", bus.req_ready);
        end
        tick();
        bus.req_valid = '0;
        set_op(0, 0, TEN, TWO);
        for (int k = 0; k < 2; k++) begin
            #1;
            n_tests++;
            if (bus.add_in1 !== ONE || bus.add_in2 !== TWO) begin
                n_fail++;
                $display("FAIL stab_hold%0d: in1=%h in2=%h expected 3f800000 40000000", k, bus.add_in1, bus.add_in2);
            end
            tick();
        end
        n_tests++;
        if (bus.resp_valid !== 1'b1 || bus.resp_data !== THREE || bus.resp_id !== 2'd0) begin
            n_fail++;
            $display("FAIL stab_resp: valid=%b data=%h id=%0d expected 1 40400000 0", bus.resp_valid, bus.resp_data, bus.resp_id);
        end
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_reset_mid_hold();
        int lat;
        bit stale;
        set_op(0, 3, ONE, ONE);
        bus.req_valid = 4'b1000;
        #1;
        n_tests++;
        if (bus.req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL rst_grant: got %b expected 1000", bus.req_ready);
        end
        tick();
        bus.req_valid = '0;
        #2 rst_n = 1'b0;
        #1;
        n_tests++;
        if ({bus.req_ready, bus.add_in1, bus.add_in2, bus.resp_valid, bus.resp_data, bus.resp_id, bus.busy} !== '0) begin
            n_fail++;
            $display("FAIL rst_async: outputs=%h expected all 0",
                     {bus.req_ready, bus.add_in1, bus.add_in2, bus.resp_valid, bus.resp_data, bus.resp_id, bus.busy});
        end
        @(posedge clk);
        #2 rst_n = 1'b1;
        stale = 1'b0;
        for (int k = 0; k < 4; k++) begin
            tick();
            if (bus.resp_valid !== 1'b0 || bus.busy !== 1'b0) stale = 1'b1;
        end
        n_tests++;
        if (stale) begin
            n_fail++;
            $display("FAIL rst_stale: resp_valid/busy seen high after reset, expected 0");
        end
        set_op(0, 2, ONE, TWO);
        bus.req_valid = 4'b0100;
        #1;
        n_tests++;
        if (bus.req_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL rst_regrant: got %b expected 0100", bus.req_ready);
        end
        tick();
        bus.req_valid = '0;
        wait_resp(0, lat);
        n_tests++;
        if (lat != 3 || bus.resp_data !== THREE || bus.resp_id !== 2'd2) begin
            n_fail++;
            $display("FAIL rst_resp: lat=%0d data=%h id=%0d expected 3 40400000 2", lat, bus.resp_data, bus.resp_id);
        end
        bus.resp_ready = 1'b1;
        tick();
        bus.resp_ready = 1'b0;
    endtask

    task automatic test_wrap_add1();
        int lat;
        int w;
        set_op(1, 3, HALF, QUART);
        set_op(1, 0, ONE, TWO);
        bus1.resp_ready = 1'b1;
        bus1.req_valid  = 4'b1000;
        #1;
        n_tests++;
        if (bus1.req_ready !== 4'b1000) begin
            n_fail++;
            $display("FAIL wrap_first: got %b expected 1000", bus1.req_ready);
        end
        tick();
        bus1.req_valid = '0;
        wait_resp(1, lat);
        n_tests++;
        if (lat != 2 || bus1.resp_data !== P75 || bus1.resp_id !== 2'd3) begin
            n_fail++;
            $display("FAIL wrap_resp3: lat=%0d data=%h id=%0d expected 2 3f400000 3", lat, bus1.resp_data, bus1.resp_id);
        end
        tick();
        bus1.req_valid = 4'b1001;
        #1;
        n_tests++;
        if (bus1.req_ready !== 4'b0001) begin
            n_fail++;
            $display("FAIL wrap_grant0: got %b expected 0001", bus1.req_ready);
        end
        tick();
        bus1.req_valid = 4'b1000;
        wait_resp(1, lat);
        n_tests++;
        if (lat != 2 || bus1.resp_data !== THREE || bus1.resp_id !== 2'd0) begin
            n_fail++;
            $display("FAIL wrap_resp0: lat=%0d data=%h id=%0d expected 2 40400000 0", lat, bus1.resp_data, bus1.resp_id);
        end
        tick();
        #1;
        wait_grant(1, w);
        n_tests++;
        if (bus1.req_ready !== 4'b1000 || w != 0) begin
            n_fail++;
            $display("FAIL wrap_grant3: got %b after %0d idle cycles expected 1000 after 0", bus1.req_ready, w);
        end
        tick();
        bus1.req_valid = '0;
        wait_resp(1, lat);
        n_tests++;
        if (lat != 2 || bus1.resp_data !== P75 || bus1.resp_id !== 2'd3) begin
            n_fail++;
            $display("FAIL wrap_resp3b: lat=%0d data=%h id=%0d expected 2 3f400000 3", lat, bus1.resp_data, bus1.resp_id);
        end
        tick();
        bus1.resp_ready = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1);
    end

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_operand_stability();
        test_reset_mid_hold();
        test_wrap_add1();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
